// File: rtl/lc3_program_loader.sv
// lc3_program_loader
// Boot loader that receives a big-endian byte stream (ORIG, LEN, data words,
// CHK), writes the words through the memory load port, verifies the additive
// checksum and then releases the processor from reset.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ORIG_HI  | waiting for high byte of the load origin
//   ORIG_LO  | waiting for low byte of the load origin
//   LEN_HI   | waiting for high byte of the word count
//   LEN_LO   | waiting for low byte of the word count
//   DATA_HI  | waiting for high byte of the next data word
//   DATA_LO  | waiting for low byte of the next data word
//   WRITE    | one-cycle memory write strobe, sum/index/count update
//   CHK_HI   | waiting for high byte of the checksum
//   CHK_LO   | waiting for low byte of the checksum
//   DONE     | checksum matched, core released (terminal until reset)
//   ERROR    | checksum mismatched, core held (terminal until reset)
module lc3_program_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  inData,
    input  logic        inValid,
    output logic        inReady,
    output logic [15:0] memAddr,
    output logic [15:0] memData,
    output logic        memWE,
    output logic        cpuHold,
    output logic        done,
    output logic        error,
    output logic [15:0] wordCount
);

    typedef enum logic [3:0] {
        S_ORIG_HI, S_ORIG_LO, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_CHK_HI, S_CHK_LO, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hi_q;
    logic [15:0] orig_q;
    logic [15:0] remaining_q;
    logic [15:0] index_q;
    logic [15:0] sum_q;
    logic [15:0] word_count_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_data_q;
    logic        xfer;

    assign xfer = inValid && inReady;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_ORIG_HI;
        else       state_q <= state_d;
    end

    // Datapath: byte assembly, write address/data capture, running sum
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q         <= 8'h00;
            orig_q       <= 16'h0000;
            remaining_q  <= 16'h0000;
            index_q      <= 16'h0000;
            sum_q        <= 16'h0000;
            word_count_q <= 16'h0000;
            mem_addr_q   <= 16'h0000;
            mem_data_q   <= 16'h0000;
        end else begin
            case (state_q)
                S_ORIG_HI, S_LEN_HI, S_DATA_HI, S_CHK_HI: begin
                    if (xfer) hi_q <= inData;
                end
                S_ORIG_LO: begin
                    if (xfer) orig_q <= {hi_q, inData};
                end
                S_LEN_LO: begin
                    if (xfer) remaining_q <= {hi_q, inData};
                end
                S_DATA_LO: begin
                    // Capture here so the port is already valid during WRITE
                    // and simply holds afterwards.
                    if (xfer) begin
                        mem_addr_q <= orig_q + index_q;
                        mem_data_q <= {hi_q, inData};
                    end
                end
                S_WRITE: begin
                    sum_q        <= sum_q + mem_data_q;
                    index_q      <= index_q + 16'd1;
                    word_count_q <= word_count_q + 16'd1;
                    remaining_q  <= remaining_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ORIG_HI: if (xfer) state_d = S_ORIG_LO;
            S_ORIG_LO: if (xfer) state_d = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_d = S_LEN_LO;
            S_LEN_LO:  if (xfer) state_d = ({hi_q, inData} != 16'h0000) ? S_DATA_HI : S_CHK_HI;
            S_DATA_HI: if (xfer) state_d = S_DATA_LO;
            S_DATA_LO: if (xfer) state_d = S_WRITE;
            // remaining_q still counts the word being written this cycle
            S_WRITE:   state_d = (remaining_q != 16'd1) ? S_DATA_HI : S_CHK_HI;
            S_CHK_HI:  if (xfer) state_d = S_CHK_LO;
            S_CHK_LO:  if (xfer) state_d = ({hi_q, inData} == sum_q) ? S_DONE : S_ERROR;
            S_DONE:    state_d = S_DONE;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_ORIG_HI;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        inReady = 1'b0;
        memWE   = 1'b0;
        cpuHold = 1'b1;
        done    = 1'b0;
        error   = 1'b0;
        case (state_q)
            S_WRITE: memWE = 1'b1;
            S_DONE: begin
                cpuHold = 1'b0;
                done    = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: inReady = 1'b1;
        endcase
    end

    assign memAddr   = mem_addr_q;
    assign memData   = mem_data_q;
    assign wordCount = word_count_q;

endmodule
